// File: rtl/nmc_feature_buf_pkg.sv
// Shared NMC feature-buffer types and defaults (float_t, feature_t, bank index, RD_LAT check).
// Optional statistics counters in nmc_feature_buf are enabled by NMC_FEATURE_BUF_STAT_EN.
`ifndef NMC_FEATURE_BUF_PKG_SV
`define NMC_FEATURE_BUF_PKG_SV

`ifndef N_FEATURE
`define N_FEATURE 16
`endif
`ifndef N_PART_FEATURE
`define N_PART_FEATURE 4
`endif

`define NMC_FBUF_RD_LAT_OK(l) (((l) == 1) || ((l) == 2))

package nmc_feature_buf_pkg;
    typedef logic [31:0] float_t;
    typedef float_t [`N_FEATURE-1:0] feature_t;

    localparam int NMC_FBUF_N_CHUNK = 8;
    localparam int NMC_FBUF_N_BANK  = 2;

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int FBUF_BANK_W = clog2_min1(NMC_FBUF_N_BANK);
    typedef logic [FBUF_BANK_W-1:0] fbuf_bank_t;
endpackage

`endif

// File: rtl/nmc_fbuf_rdport.sv
// One partition read port: bank/partition mux, ce gating and RD_LAT output pipe.
// Idle ports still shift zeros through the pipe so rddata reads 0 when not valid.
module nmc_fbuf_rdport
    import nmc_feature_buf_pkg::*;
#(
    parameter int N_PART = 4,
    parameter int N_BANK = 2,
    parameter int RD_LAT = 1,
    parameter int AW     = 2,
    parameter int BW     = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   avail,
    input  logic                   ce,
    input  logic [AW-1:0]          addr,
    input  logic [BW-1:0]          rbank,
    input  float_t [N_PART-1:0]    part [N_BANK],
    output float_t                 rddata,
    output logic                   rddata_vld
);
    logic                issue;
    float_t [N_PART-1:0] sel;
    float_t              d_q [RD_LAT];
    logic [RD_LAT-1:0]   v_q;

    assign issue = ce & avail;
    assign sel   = part[rbank];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < RD_LAT; k++) begin
                d_q[k] <= '0;
            end
            v_q <= '0;
        end else begin
            d_q[0] <= issue ? sel[addr] : '0;
            v_q[0] <= issue;
            for (int k = 1; k < RD_LAT; k++) begin
                d_q[k] <= d_q[k-1];
                v_q[k] <= v_q[k-1];
            end
        end
    end

    assign rddata     = d_q[RD_LAT-1];
    assign rddata_vld = v_q[RD_LAT-1];
endmodule

// File: rtl/nmc_feature_buf.sv
// Multi-bank feature buffer: streamed beat writer, N_PORT partition readers.
// `define NMC_FEATURE_BUF_STAT_EN adds stat_stall / stat_feat counters.
module nmc_feature_buf
    import nmc_feature_buf_pkg::*;
#(
    parameter int N_TOTAL = `N_FEATURE,
    parameter int N_PART  = `N_PART_FEATURE,
    parameter int N_CHUNK = NMC_FBUF_N_CHUNK,
    parameter int N_BANK  = NMC_FBUF_N_BANK,
    parameter int RD_LAT  = 1,
    localparam int N_PORT = N_TOTAL / N_PART,
    localparam int N_BEAT = N_TOTAL / N_CHUNK,
    localparam int AW     = clog2_min1(N_PART)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_valid,
    output logic                         wr_ready,
    input  float_t [N_CHUNK-1:0]         wr_data,
    input  logic                         wr_last,
    output logic                         rd_avail,
    input  logic                         rd_release,
    input  logic [N_PORT-1:0]            ce,
    input  logic [N_PORT-1:0][AW-1:0]    rdaddr,
    output float_t [N_PORT-1:0]          rddata,
    output logic [N_PORT-1:0]            rddata_vld,
    output logic                         err_len
`ifdef NMC_FEATURE_BUF_STAT_EN
    ,
    output logic [31:0]                  stat_stall,
    output logic [31:0]                  stat_feat
`endif
);
    localparam int BW  = clog2_min1(N_BANK);
    localparam int BTW = clog2_min1(N_BEAT);
    localparam int FCW = $clog2(N_BANK + 1);

    if (!`NMC_FBUF_RD_LAT_OK(RD_LAT)) begin : g_bad_rd_lat
        $error("nmc_feature_buf: RD_LAT must be 1 or 2");
    end

    float_t [N_CHUNK-1:0] mem [N_BANK][N_BEAT];
    float_t [N_TOTAL-1:0] flat [N_BANK];

    logic [BW-1:0]  wbank, rbank;
    logic [BTW-1:0] beat;
    logic [FCW-1:0] full_cnt;
    logic           accept, final_beat, commit, early_last, release_ok;

    assign wr_ready   = full_cnt < FCW'(N_BANK);
    assign rd_avail   = full_cnt != '0;
    assign accept     = wr_valid & wr_ready;
    assign final_beat = beat == BTW'(N_BEAT - 1);
    assign commit     = accept & final_beat;
    assign early_last = accept & wr_last & ~final_beat;
    assign release_ok = rd_release & rd_avail;

    // Storage is never reset; only the pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wbank][beat] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wbank    <= '0;
            rbank    <= '0;
            beat     <= '0;
            full_cnt <= '0;
            err_len  <= 1'b0;
        end else begin
            if (accept) begin
                beat <= (final_beat | wr_last) ? '0 : beat + BTW'(1);
            end
            if (commit) begin
                wbank <= wbank + BW'(1);
            end
            if (release_ok) begin
                rbank <= rbank + BW'(1);
            end
            if (commit & ~release_ok) begin
                full_cnt <= full_cnt + FCW'(1);
            end else if (release_ok & ~commit) begin
                full_cnt <= full_cnt - FCW'(1);
            end
            if (early_last | (commit & ~wr_last)) begin
                err_len <= 1'b1;
            end
        end
    end

    always_comb begin
        for (int b = 0; b < N_BANK; b++) begin
            flat[b] = '0;
            for (int bt = 0; bt < N_BEAT; bt++) begin
                flat[b][bt*N_CHUNK +: N_CHUNK] = mem[b][bt];
            end
        end
    end

    for (genvar i = 0; i < N_PORT; i++) begin : g_port
        float_t [N_PART-1:0] part [N_BANK];

        for (genvar b = 0; b < N_BANK; b++) begin : g_bank
            assign part[b] = flat[b][i*N_PART +: N_PART];
        end

        nmc_fbuf_rdport #(
            .N_PART (N_PART),
            .N_BANK (N_BANK),
            .RD_LAT (RD_LAT),
            .AW     (AW),
            .BW     (BW)
        ) u_rdport (
            .clk        (clk),
            .rst        (rst),
            .avail      (rd_avail),
            .ce         (ce[i]),
            .addr       (rdaddr[i]),
            .rbank      (rbank),
            .part       (part),
            .rddata     (rddata[i]),
            .rddata_vld (rddata_vld[i])
        );
    end

`ifdef NMC_FEATURE_BUF_STAT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_stall <= '0;
            stat_feat  <= '0;
        end else begin
            if (wr_valid & ~wr_ready & ~&stat_stall) begin
                stat_stall <= stat_stall + 32'd1;
            end
            if (commit & ~&stat_feat) begin
                stat_feat <= stat_feat + 32'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_nmc_feature_buf.sv
// Directed bench: RD_LAT=1 and RD_LAT=2 instances share one stimulus stream.
// With NMC_FEATURE_BUF_STAT_EN defined the stat counters are also checked.
module tb_nmc_feature_buf;
    import nmc_feature_buf_pkg::*;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                wr_valid = 1'b0;
    logic                wr_last = 1'b0;
    logic                rd_release = 1'b0;
    float_t [3:0]        wr_data = '0;
    logic [3:0]          ce = '0;
    logic [3:0][1:0]     rdaddr = '0;

    logic                wr_ready1, rd_avail1, err1;
    logic                wr_ready2, rd_avail2, err2;
    float_t [3:0]        rddata1, rddata2;
    logic [3:0]          vld1, vld2;
`ifdef NMC_FEATURE_BUF_STAT_EN
    logic [31:0]         stall1, feat1, stall2, feat2;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    nmc_feature_buf #(
        .N_TOTAL(16), .N_PART(4), .N_CHUNK(4), .N_BANK(2), .RD_LAT(1)
    ) dut1 (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready1),
        .wr_data(wr_data), .wr_last(wr_last), .rd_avail(rd_avail1),
        .rd_release(rd_release), .ce(ce), .rdaddr(rdaddr),
        .rddata(rddata1), .rddata_vld(vld1), .err_len(err1)
`ifdef NMC_FEATURE_BUF_STAT_EN
        , .stat_stall(stall1), .stat_feat(feat1)
`endif
    );

    nmc_feature_buf #(
        .N_TOTAL(16), .N_PART(4), .N_CHUNK(4), .N_BANK(2), .RD_LAT(2)
    ) dut2 (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready2),
        .wr_data(wr_data), .wr_last(wr_last), .rd_avail(rd_avail2),
        .rd_release(rd_release), .ce(ce), .rdaddr(rdaddr),
        .rddata(rddata2), .rddata_vld(vld2), .err_len(err2)
`ifdef NMC_FEATURE_BUF_STAT_EN
        , .stat_stall(stall2), .stat_feat(feat2)
`endif
    );

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] exp_rd(input int base, input int a);
        logic [127:0] r;
        for (int i = 0; i < 4; i++) begin
            r[i*32 +: 32] = 32'(base + i*4 + a);
        end
        return r;
    endfunction

    task automatic send(input int base, input bit last, input bit rel);
        wr_valid   = 1'b1;
        wr_last    = last;
        rd_release = rel;
        for (int j = 0; j < 4; j++) begin
            wr_data[j] = 32'(base + j);
        end
        @(posedge clk);
        #1;
        wr_valid   = 1'b0;
        wr_last    = 1'b0;
        rd_release = 1'b0;
    endtask

    task automatic send_vec(input int base, input bit with_last);
        for (int b = 0; b < 4; b++) begin
            send(base + 4*b, with_last && (b == 3), 1'b0);
        end
    endtask

    task automatic pulse_rel();
        rd_release = 1'b1;
        @(posedge clk);
        #1;
        rd_release = 1'b0;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input int a,
                          input logic [127:0] exp);
        ce = 4'hf;
        for (int i = 0; i < 4; i++) begin
            rdaddr[i] = 2'(a);
        end
        @(posedge clk);
        #1;
        ce = '0;
        chk({tag, "_d1"}, rddata1, exp);
        chk({tag, "_v1"}, 128'(vld1), 128'hf);
        chk({tag, "_v2_early"}, 128'(vld2), 128'h0);
        @(posedge clk);
        #1;
        chk({tag, "_d2"}, rddata2, exp);
        chk({tag, "_v2"}, 128'(vld2), 128'hf);
        chk({tag, "_v1_off"}, 128'(vld1), 128'h0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_avail", 128'(rd_avail1), 128'h0);
        chk("rst_ready", 128'(wr_ready1), 128'h1);
        chk("rst_err", 128'(err1), 128'h0);
        chk("rst_vld", 128'({vld2, vld1}), 128'h0);
        chk("rst_data", rddata1, 128'h0);

        // vector A = 0..15
        send_vec(0, 1'b1);
        chk("t1_avail", 128'(rd_avail1), 128'h1);
        rd_chk("t1_read", 1, {32'd13, 32'd9, 32'd5, 32'd1});

        // vector B = 100..115, then offer C beat 0 while full
        send_vec(100, 1'b1);
        chk("t2_full_ready", 128'(wr_ready1), 128'h0);
        wr_valid = 1'b1;
        for (int j = 0; j < 4; j++) begin
            wr_data[j] = 32'(900 + j);
        end
        repeat (3) @(posedge clk);
        #1;
        chk("t2_stall_ready", 128'(wr_ready2), 128'h0);
        wr_valid = 1'b0;
        rd_chk("t2_read_a", 0, exp_rd(0, 0));
        pulse_rel();
        chk("t2_refill_ready", 128'(wr_ready1), 128'h1);
        rd_chk("t2_read_b", 2, exp_rd(100, 2));

        // vector C commits in the same cycle B is released
        send(200, 1'b0, 1'b0);
        send(204, 1'b0, 1'b0);
        send(208, 1'b0, 1'b0);
        send(212, 1'b1, 1'b1);
        chk("t3_avail", 128'(rd_avail1), 128'h1);
        chk("t3_ready", 128'(wr_ready1), 128'h1);
        rd_chk("t3_read_c", 3, exp_rd(200, 3));

        // early wr_last discards, then clean vector D
        send(300, 1'b0, 1'b0);
        send(304, 1'b1, 1'b0);
        chk("t4_err", 128'(err1), 128'h1);
        chk("t4_nocommit", 128'(wr_ready1), 128'h1);
        send_vec(400, 1'b1);
        chk("t4_commit_d", 128'(wr_ready1), 128'h0);
        pulse_rel();
        rd_chk("t4_read_d", 0, exp_rd(400, 0));
        pulse_rel();
        chk("t4_empty", 128'(rd_avail1), 128'h0);
        // vector E without wr_last still commits
        send_vec(500, 1'b0);
        chk("t4_commit_e", 128'(rd_avail1), 128'h1);
        chk("t4_err_sticky", 128'(err2), 128'h1);
        rd_chk("t4_read_e", 1, exp_rd(500, 1));
`ifdef NMC_FEATURE_BUF_STAT_EN
        chk("t6_stat_stall", 128'(stall2), 128'd3);
        chk("t6_stat_feat", 128'(feat2), 128'd5);
`endif

        // reset clears err, drops the partial vector, gates reads
        pulse_rst();
        chk("t5_err_clr", 128'(err1), 128'h0);
        chk("t5_avail", 128'(rd_avail1), 128'h0);
        send(600, 1'b0, 1'b0);
        send(604, 1'b0, 1'b0);
        pulse_rst();
        ce = 4'hf;
        for (int i = 0; i < 4; i++) begin
            rdaddr[i] = 2'd0;
        end
        @(posedge clk);
        #1;
        chk("t5_gate_avail", 128'(rd_avail1), 128'h0);
        chk("t5_gate_vld1", 128'(vld1), 128'h0);
        chk("t5_gate_data1", rddata1, 128'h0);
        @(posedge clk);
        #1;
        ce = '0;
        chk("t5_gate_vld2", 128'(vld2), 128'h0);
        chk("t5_gate_data2", rddata2, 128'h0);
        pulse_rel();
        chk("t5_rel_ignored", 128'(rd_avail1), 128'h0);
        send_vec(700, 1'b1);
        chk("t5_avail_after", 128'(rd_avail1), 128'h1);
        rd_chk("t5_read", 0, exp_rd(700, 0));
`ifdef NMC_FEATURE_BUF_STAT_EN
        chk("t6_stall_rst", 128'(stall1), 128'd0);
        chk("t6_feat_rst", 128'(feat1), 128'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
